// File: rtl/capture3_threshold_trigger_if.sv
// Bundle of the capture3 trigger's data-path signals.
// master: the side supplying threshold/arm/samples and consuming the capture stream.
// slave:  the trigger block itself.
interface capture3_threshold_trigger_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 8,
    parameter int ADDR_W = 10
);
    logic        [31:0]       threshold;
    logic                     arm;
    logic        [CH_W-1:0]   ch_sel;
    logic                     din_valid;
    logic        [CH_W-1:0]   ch_id;
    logic signed [DATA_W-1:0] din;
    logic                     trig;
    logic                     busy;
    logic                     cap_we;
    logic        [ADDR_W-1:0] cap_addr;
    logic signed [DATA_W-1:0] cap_data;
    logic                     cap_done;
    logic        [31:0]       event_count;

    modport master (
        output threshold, arm, ch_sel, din_valid, ch_id, din,
        input  trig, busy, cap_we, cap_addr, cap_data, cap_done, event_count
    );

    modport slave (
        input  threshold, arm, ch_sel, din_valid, ch_id, din,
        output trig, busy, cap_we, cap_addr, cap_data, cap_done, event_count
    );
endinterface

// File: rtl/capture3_threshold_trigger.sv
// Threshold trigger and fixed-length snapshot writer for the capture3 path.
// Watches one channel of the phase stream; when a selected sample drops strictly
// below the signed threshold it streams CAP_LEN selected samples into the snapshot
// BRAM, then waits HOLDOFF cycles before re-arming.
// Optional: define CAPTURE3_PRETRIG_EN to capture PRETRIG selected samples ahead of
// the hit sample through a delay line (hit sample lands at address PRETRIG).
module capture3_threshold_trigger #(
    parameter int DATA_W  = 16,
    parameter int CH_W    = 8,
    parameter int ADDR_W  = 10,
    parameter int CAP_LEN = 1024,
    parameter int HOLDOFF = 256,
    parameter int PRETRIG = 32
) (
    input  logic                           user_clk,
    input  logic                           user_rst_n,
    capture3_threshold_trigger_if.slave    bus
);
    localparam int HOLD_W = $clog2(HOLDOFF + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CAP_LEN - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLDOFF_ST} state_t;

    state_t                   state;
    logic signed [DATA_W-1:0] thr_q;
    logic        [ADDR_W-1:0] wr_cnt;
    logic        [HOLD_W-1:0] hold_cnt;

    logic                     trig_reg;
    logic                     busy_reg;
    logic                     cap_we_reg;
    logic        [ADDR_W-1:0] cap_addr_reg;
    logic signed [DATA_W-1:0] cap_data_reg;
    logic                     cap_done_reg;
    logic        [31:0]       event_count_reg;

    logic                     sel;
    logic                     hit;
    logic signed [DATA_W-1:0] wr_sample;

    // Only the low DATA_W bits of the register word carry the threshold.
    generate
        if (DATA_W < 32) begin : g_thr_unused
            logic unused_thr_bits;
            assign unused_thr_bits = ^bus.threshold[31:DATA_W];
        end
    endgenerate

    assign sel = bus.din_valid && (bus.ch_id == bus.ch_sel);
    assign hit = sel && (bus.din < thr_q);

`ifdef CAPTURE3_PRETRIG_EN
    logic signed [DATA_W-1:0] dly [PRETRIG];

    // Pre-trigger delay line: advances only on selected samples, in every state.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            for (int i = 0; i < PRETRIG; i++) dly[i] <= '0;
        end else if (sel) begin
            dly[0] <= bus.din;
            for (int i = 1; i < PRETRIG; i++) dly[i] <= dly[i-1];
        end
    end

    assign wr_sample = dly[PRETRIG-1];
`else
    assign wr_sample = bus.din;
`endif

    // Threshold register: a software write is seen by the comparator one cycle later.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) thr_q <= '0;
        else             thr_q <= bus.threshold[DATA_W-1:0];
    end

    // Trigger/capture/holdoff sequencer with registered outputs.
    // HOLDOFF_ST is entered on the edge that issues the last write, so its first
    // cycle raises cap_done and busy drops after HOLDOFF visible holdoff cycles.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state           <= IDLE;
            wr_cnt          <= '0;
            hold_cnt        <= '0;
            trig_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            cap_we_reg      <= 1'b0;
            cap_addr_reg    <= '0;
            cap_data_reg    <= '0;
            cap_done_reg    <= 1'b0;
            event_count_reg <= '0;
        end else begin
            trig_reg     <= 1'b0;
            cap_we_reg   <= 1'b0;
            cap_done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.arm) state <= ARMED;
                end
                ARMED: begin
                    if (!bus.arm) begin
                        state <= IDLE;
                    end else if (hit) begin
                        state           <= CAPTURE;
                        trig_reg        <= 1'b1;
                        busy_reg        <= 1'b1;
                        cap_we_reg      <= 1'b1;
                        cap_addr_reg    <= '0;
                        cap_data_reg    <= wr_sample;
                        event_count_reg <= event_count_reg + 32'd1;
                        wr_cnt          <= ADDR_W'(1);
                    end
                end
                CAPTURE: begin
                    if (sel) begin
                        cap_we_reg   <= 1'b1;
                        cap_addr_reg <= wr_cnt;
                        cap_data_reg <= wr_sample;
                        wr_cnt       <= wr_cnt + ADDR_W'(1);
                        if (wr_cnt == LAST_ADDR) begin
                            state    <= HOLDOFF_ST;
                            hold_cnt <= '0;
                        end
                    end
                end
                HOLDOFF_ST: begin
                    if (hold_cnt == '0) cap_done_reg <= 1'b1;
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (hold_cnt == HOLD_W'(HOLDOFF)) begin
                        state    <= IDLE;
                        busy_reg <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.trig        = trig_reg;
    assign bus.busy        = busy_reg;
    assign bus.cap_we      = cap_we_reg;
    assign bus.cap_addr    = cap_addr_reg;
    assign bus.cap_data    = cap_data_reg;
    assign bus.cap_done    = cap_done_reg;
    assign bus.event_count = event_count_reg;
endmodule

// File: tb/tb_capture3_threshold_trigger.sv
// Directed bench for capture3_threshold_trigger with CAP_LEN=8, HOLDOFF=4, PRETRIG=4.
module tb_capture3_threshold_trigger;
    localparam int DATA_W  = 16;
    localparam int CH_W    = 8;
    localparam int ADDR_W  = 10;
    localparam int CAP_LEN = 8;
    localparam int HOLDOFF = 4;
    localparam int PRETRIG = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic signed [DATA_W-1:0] mem [CAP_LEN];

    capture3_threshold_trigger_if #(.DATA_W(DATA_W), .CH_W(CH_W), .ADDR_W(ADDR_W)) bus ();

    capture3_threshold_trigger #(
        .DATA_W(DATA_W), .CH_W(CH_W), .ADDR_W(ADDR_W),
        .CAP_LEN(CAP_LEN), .HOLDOFF(HOLDOFF), .PRETRIG(PRETRIG)
    ) dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Record every buffer write, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.cap_we) mem[bus.cap_addr[2:0]] = bus.cap_data;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("check %-18s got %0d", tag, obs);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle: apply a sample mid-cycle, return just after the edge that registers it.
    task automatic drive(input logic v, input logic [CH_W-1:0] ch, input int d);
        @(negedge clk);
        bus.din_valid = v;
        bus.ch_id     = ch;
        bus.din       = DATA_W'(d);
        @(posedge clk);
        #1;
    endtask

    // Feed non-hitting channel-3 samples until busy drops (bounded).
    task automatic drain(input string tag);
        int n = 0;
        while (bus.busy && n < 100) begin
            drive(1'b1, 8'd3, 0);
            n++;
        end
        check(tag, bus.busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"}, {bus.trig, bus.busy, bus.cap_we, bus.cap_done,
                             bus.cap_addr != 0, bus.cap_data != 0}, 0);
        check({tag, "_evcnt"}, bus.event_count, 0);
    endtask

    initial begin
        bus.threshold = 32'hFFFFFF00;
        bus.arm       = 1'b1;
        bus.ch_sel    = 8'd3;
        bus.din_valid = 1'b0;
        bus.ch_id     = '0;
        bus.din       = '0;
        for (int i = 0; i < CAP_LEN; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'd0, 0);
        drive(1'b0, 8'd0, 0);

        // 1: first trigger on -300 (threshold -256)
        drive(1'b1, 8'd3, -100);
        check("t1_no_trig_a", bus.trig, 0);
        drive(1'b1, 8'd3, -200);
        check("t1_no_trig_b", bus.trig, 0);
        drive(1'b1, 8'd3, -300);
        check("t1_trig", bus.trig, 1);
        check("t1_we", bus.cap_we, 1);
        check("t1_addr", bus.cap_addr, 0);
`ifndef CAPTURE3_PRETRIG_EN
        check("t1_data", $signed(bus.cap_data), -300);
`endif
        check("t1_evcnt", bus.event_count, 1);
        check("t1_busy", bus.busy, 1);

        // 2: selected samples every 2nd cycle; hits during capture ignored
        for (int k = 1; k < CAP_LEN; k++) begin
            drive(1'b0, 8'd3, 0);
            check($sformatf("t2_gap_we%0d", k), bus.cap_we, 0);
            check($sformatf("t2_gap_addr%0d", k), bus.cap_addr, k - 1);
            drive(1'b1, 8'd3, -1000 - k);
            check($sformatf("t2_we%0d", k), bus.cap_we, 1);
            check($sformatf("t2_addr%0d", k), bus.cap_addr, k);
`ifndef CAPTURE3_PRETRIG_EN
            check($sformatf("t2_data%0d", k), $signed(bus.cap_data), -1000 - k);
`endif
            check($sformatf("t2_notrig%0d", k), bus.trig, 0);
        end
        drive(1'b0, 8'd3, 0);
        check("t2_done", bus.cap_done, 1);
        check("t2_done_busy", bus.busy, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'd3, -2000);
            check($sformatf("t2_hold_busy%0d", k), bus.busy, 1);
            check($sformatf("t2_hold_trig%0d", k), bus.trig, 0);
            check($sformatf("t2_hold_done%0d", k), bus.cap_done, 0);
        end
        drive(1'b0, 8'd3, 0);
        check("t2_busy_low", bus.busy, 0);
        drive(1'b0, 8'd3, 0);
        check("t2_evcnt", bus.event_count, 1);
        // level trigger after holdoff
        drive(1'b1, 8'd3, -300);
        check("t2_retrig", bus.trig, 1);
        check("t2_evcnt2", bus.event_count, 2);
        drain("t2_drain");
        drive(1'b0, 8'd3, 0);
        drive(1'b0, 8'd3, 0);

        // 3: equality does not trigger; threshold change applies one cycle later
        drive(1'b1, 8'd3, -256);
        check("t3_equal", bus.trig, 0);
        bus.threshold = 32'hFFFFFF01;
        drive(1'b1, 8'd3, -256);
        check("t3_thr_latency", bus.trig, 0);
        drive(1'b1, 8'd3, -256);
        check("t3_trig", bus.trig, 1);
        check("t3_evcnt", bus.event_count, 3);
        drain("t3_drain");
        bus.threshold = 32'hFFFFFF00;
        drive(1'b0, 8'd3, 0);
        drive(1'b0, 8'd3, 0);

        // 4: other channel ignored; interleaved channels during capture
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'd5, -1000);
            check($sformatf("t4_ch5_trig%0d", k), bus.trig, 0);
            check($sformatf("t4_ch5_we%0d", k), bus.cap_we, 0);
        end
        drive(1'b1, 8'd3, -300);
        check("t4_trig", bus.trig, 1);
        for (int k = 1; k < CAP_LEN; k++) begin
            drive(1'b1, 8'd5, -5000);
            check($sformatf("t4_ch5_skip%0d", k), bus.cap_we, 0);
            drive(1'b1, 8'd3, 10 * k);
            check($sformatf("t4_addr%0d", k), bus.cap_addr, k);
`ifndef CAPTURE3_PRETRIG_EN
            check($sformatf("t4_data%0d", k), $signed(bus.cap_data), 10 * k);
`endif
        end
        drive(1'b1, 8'd5, -5000);
        check("t4_done", bus.cap_done, 1);
        drain("t4_drain");
        check("t4_evcnt", bus.event_count, 4);
        drive(1'b0, 8'd3, 0);
        drive(1'b0, 8'd3, 0);

        // 5: arm dropped mid-capture, then asynchronous reset mid-capture
        drive(1'b1, 8'd3, -300);
        check("t5_trig", bus.trig, 1);
        bus.arm = 1'b0;
        for (int k = 1; k < CAP_LEN; k++) drive(1'b1, 8'd3, 0);
        check("t5_last_addr", bus.cap_addr, CAP_LEN - 1);
        drive(1'b0, 8'd3, 0);
        check("t5_done", bus.cap_done, 1);
        drain("t5_drain");
        begin
            int trig_seen = 0;
            for (int k = 0; k < 10; k++) begin
                drive(1'b1, 8'd3, -300);
                trig_seen += bus.trig;
            end
            check("t5_disarmed_trigs", trig_seen, 0);
        end
        check("t5_evcnt", bus.event_count, 5);
        bus.arm = 1'b1;
        drive(1'b0, 8'd3, 0);
        drive(1'b0, 8'd3, 0);
        drive(1'b1, 8'd3, -300);
        check("t5_rearm_trig", bus.trig, 1);
        drive(1'b1, 8'd3, -1);
        drive(1'b1, 8'd3, -2);
        drive(1'b1, 8'd3, -3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async_rst");

        // 6: ramp with pre-trigger (or plain capture in the default build)
        bus.threshold = 32'hFFFFFFF7;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'd3, 0);
        drive(1'b0, 8'd3, 0);
        for (int i = 0; i <= 17; i++) begin
            drive(1'b1, 8'd3, -i);
            if (i == 10) check("t6_trig", bus.trig, 1);
        end
        drive(1'b0, 8'd3, 0);
        check("t6_done", bus.cap_done, 1);
`ifdef CAPTURE3_PRETRIG_EN
        check("t6_mem0", mem[0], -6);
        check("t6_mem4", mem[4], -10);
        check("t6_mem7", mem[7], -13);
`else
        check("t6_mem0", mem[0], -10);
        check("t6_mem4", mem[4], -14);
        check("t6_mem7", mem[7], -17);
`endif
        check("t6_evcnt", bus.event_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/capture3_threshold_trigger.md
Name: capture3_threshold_trigger

Overview:
- Photon-event trigger and capture stage for the capture3 path. It consumes the software threshold word (the capture3_threshold register's user_data_out, already in the user_clk domain) and compares it against the selected channel of the phase stream.
- On a threshold crossing it writes a fixed-length snapshot of that channel into a downstream snapshot BRAM, then waits out a holdoff before re-arming.
- It sits between the channelizer/phase output and the capture3 snapshot memory.

Parameters:
DATA_W, 16, width of signed phase samples and of the used threshold field
CH_W, 8, channel index width
ADDR_W, 10, capture buffer address width
CAP_LEN, 1024, samples per capture; 2 <= CAP_LEN <= 2^ADDR_W
HOLDOFF, 256, clock cycles in HOLDOFF after a capture; >= 1
PRETRIG, 32, pre-trigger depth in selected samples; used only with the optional feature

Ports:
user_clk  in  1  single clock
user_rst_n  in  1  reset, asynchronous, active-low
threshold  in  32  threshold register word; bits [DATA_W-1:0] are a signed threshold, upper bits ignored
arm  in  1  level; enables triggering
ch_sel  in  CH_W  channel to monitor
din_valid  in  1  sample strobe
ch_id  in  CH_W  channel of din
din  in  DATA_W  signed phase sample
trig  out  1  one-cycle pulse on trigger
busy  out  1  high in CAPTURE or HOLDOFF
cap_we  out  1  buffer write enable
cap_addr  out  ADDR_W  buffer write address
cap_data  out  DATA_W  buffer write data
cap_done  out  1  one-cycle pulse after the last write
event_count  out  32  triggers since reset

Behaviour:
- Reset (user_rst_n low, asynchronous): state IDLE; all outputs 0; counters 0; pre-trigger line cleared.
- Selected sample: din_valid=1 and ch_id==ch_sel. All other cycles are ignored by the comparator and by capture.
- Threshold path:
  - threshold[DATA_W-1:0] is registered into thr_q every cycle.
  - A register write therefore takes effect on comparisons one cycle later.
  - Comparison is signed and strict: hit = sel && (din < thr_q).
- States:
  - IDLE: if arm=1, go to ARMED next cycle.
  - ARMED: if arm=0, go to IDLE. Otherwise, on hit, go to CAPTURE.
  - CAPTURE: write CAP_LEN selected samples, then go to HOLDOFF.
  - HOLDOFF: count HOLDOFF cycles, then go to IDLE (ARMED on the following cycle if arm=1).
- Trigger timing, relative to the hit sample in cycle T (all outputs registered):
  - At T+1: trig=1, cap_we=1, cap_addr=0, cap_data=hit sample, event_count incremented.
- Capture sequence:
  - Each subsequent selected sample produces a write one cycle later at the next address, 1..CAP_LEN-1.
  - Cycles with no selected sample have cap_we=0.
  - cap_done pulses in the cycle after the write to address CAP_LEN-1; HOLDOFF starts that same cycle.
- Flags and counters:
  - busy=1 from the trig cycle through the last HOLDOFF cycle.
  - cap_addr holds its last value when cap_we=0.
  - event_count wraps from 0xFFFFFFFF to 0.
- Level trigger: if samples remain below threshold after HOLDOFF and arm=1, a new trigger fires on the first selected hit in ARMED.
- arm deasserted during CAPTURE/HOLDOFF: the capture and holdoff complete; the block then stays in IDLE.
- ch_sel changed mid-capture: takes effect immediately for selection; this is software's responsibility to avoid.
- Hits during CAPTURE/HOLDOFF are ignored and are not counted.

Optional Feature:
CAPTURE3_PRETRIG_EN
- Defined:
  - Selected samples pass through a PRETRIG-deep delay line (advancing only on selected samples); cap_data is taken from the delay line output.
  - Address 0 holds the sample PRETRIG selected samples before the hit sample; the hit sample lands at address PRETRIG.
  - Delay-line entries not yet filled since reset read as 0.
  - Trigger detection always uses the undelayed din.
- Undefined: no delay line; cap_data is din registered; the hit sample is at address 0.

Test Plan:
1. Reset, arm=1, ch_sel=3, threshold=0xFFFFFF00 (-256), channel-3 samples -100,-200,-300 -> trig one cycle after the -300 sample; cap_addr=0 with cap_data=-300; event_count=1.
2. CAP_LEN=8, HOLDOFF=4, selected samples on every 2nd cycle -> writes at addresses 0..7 with gaps; cap_done one cycle after address 7; busy low 4 cycles later; no trig from hits during busy.
3. Sample equal to threshold (-256) -> no trigger. Threshold changed to -255 -> the next -256 sample triggers.
4. Channel 5 samples at -1000 with ch_sel=3 -> no trig, no writes. Interleave channels 3 and 5 during capture -> only channel-3 samples are written.
5. Deassert arm during CAPTURE -> capture completes, then the block stays IDLE with no further triggers. Assert user_rst_n low mid-capture -> all outputs 0 immediately, state IDLE.
6. With CAPTURE3_PRETRIG_EN, PRETRIG=4, ramp 0,-1,-2,... on channel 3, threshold -9 -> addr 0=-6, addr 4=-10 (hit sample).
